// File: rtl/tag_array_pkg.sv
// Shared types and pure functions for the set-associative tag array:
// controller states plus the true-LRU age update and victim selection rules.
package tag_array_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Functions work on vectors sized for the largest legal associativity;
    // callers pad their ways into these and pass the real way count.
    localparam int MAX_WAYS     = 8;
    localparam int MAX_WAY_BITS = 3;

    typedef logic [MAX_WAYS-1:0][MAX_WAY_BITS-1:0] age_vec_t;
    typedef logic [MAX_WAYS-1:0]                   valid_vec_t;

    // Touched way becomes MRU (age 0); ways younger than it age by one.
    function automatic age_vec_t age_update(input age_vec_t                ages,
                                            input logic [MAX_WAY_BITS-1:0] way,
                                            input int                      ways);
        age_vec_t                res;
        logic [MAX_WAY_BITS-1:0] old_age;
        res     = ages;
        old_age = ages[way];
        for (int w = 0; w < MAX_WAYS; w++) begin
            if (w < ways) begin
                if (w == int'(way)) begin
                    res[w] = '0;
                end else if (ages[w] < old_age) begin
                    res[w] = ages[w] + MAX_WAY_BITS'(1);
                end
            end
        end
        return res;
    endfunction

    // Lowest-index invalid way wins; otherwise the way holding the oldest age.
    function automatic logic [MAX_WAY_BITS-1:0] victim_select(input valid_vec_t valid,
                                                              input age_vec_t   ages,
                                                              input int         ways);
        logic [MAX_WAY_BITS-1:0] victim;
        logic                    found;
        victim = '0;
        found  = 1'b0;
        for (int w = 0; w < MAX_WAYS; w++) begin
            if (w < ways && !found && !valid[w]) begin
                victim = MAX_WAY_BITS'(w);
                found  = 1'b1;
            end
        end
        if (!found) begin
            for (int w = 0; w < MAX_WAYS; w++) begin
                if (w < ways && int'(ages[w]) == ways - 1) begin
                    victim = MAX_WAY_BITS'(w);
                end
            end
        end
        return victim;
    endfunction

endpackage

// File: rtl/tag_lru_update.sv
// Combinational true-LRU next-age vector for one set, given the way being touched.
module tag_lru_update
    import tag_array_pkg::*;
#(
    parameter int WAYS     = 4,
    parameter int WAY_BITS = 2
) (
    input  logic [WAYS-1:0][WAY_BITS-1:0] ages,
    input  logic [WAY_BITS-1:0]           way,
    output logic [WAYS-1:0][WAY_BITS-1:0] next_ages
);

    age_vec_t ages_pad;
    age_vec_t ages_upd;
    logic     unused_upper;

    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        ages_pad  = '0;
        next_ages = '0;
        for (int w = 0; w < WAYS; w++) begin
            ages_pad[w] = MAX_WAY_BITS'(ages[w]);
        end
        ages_upd = age_update(ages_pad, MAX_WAY_BITS'(way), WAYS);
        for (int w = 0; w < WAYS; w++) begin
            next_ages[w] = WAY_BITS'(ages_upd[w]);
        end
    end

    // Entries above WAYS are padding and carry nothing.
    assign unused_upper = ^ages_upd;

endmodule

// File: rtl/tag_array_assoc.sv
// N-way set-associative tag store: tag compare, true-LRU victim choice,
// single-line invalidate and a one-set-per-cycle invalidate-all sweep.
module tag_array_assoc
    import tag_array_pkg::*;
#(
    parameter  int SET_BITS = 10,
    parameter  int TAG_W    = 37,
    parameter  int WAYS     = 4,
    localparam int WAY_BITS = $clog2(WAYS)
) (
    input  logic                clk,
    input  logic                gen_reset,
    output logic                ready,
    input  logic                flush_req,
    input  logic                lookup_en,
    input  logic [SET_BITS-1:0] lookup_set,
    input  logic [TAG_W-1:0]    lookup_tag,
    output logic                hit_valid,
    output logic                hit,
    output logic [WAY_BITS-1:0] hit_way,
    output logic [WAY_BITS-1:0] victim_way,
    input  logic                fill_en,
    input  logic [SET_BITS-1:0] fill_set,
    input  logic [TAG_W-1:0]    fill_tag,
    output logic [WAY_BITS-1:0] fill_way,
    input  logic                inv_en,
    input  logic [SET_BITS-1:0] inv_set,
    input  logic [TAG_W-1:0]    inv_tag
);

    localparam int SETS = 1 << SET_BITS;

    typedef logic [WAYS-1:0][WAY_BITS-1:0] ages_t;

    logic [TAG_W-1:0] tag_mem   [SETS][WAYS];
    logic [WAYS-1:0]  valid_mem [SETS];
    ages_t            age_mem   [SETS];

    state_t              state;
    logic [SET_BITS-1:0] sweep_cnt;
    logic                accept;

    logic                lk_hit;
    logic [WAY_BITS-1:0] lk_way;
    logic [WAY_BITS-1:0] lk_victim;
    logic [WAY_BITS-1:0] fl_victim;
    logic                inv_hit;
    logic [WAY_BITS-1:0] inv_way;
    logic                fill_do;
    logic                inv_do;
    logic                lru_do;
    ages_t               init_ages;
    ages_t               upd_in_ages;
    logic [WAY_BITS-1:0] upd_way;
    ages_t               upd_ages;
    ages_t               lk_next_ages;

    function automatic age_vec_t pad_ages(input ages_t a);
        age_vec_t r;
        r = '0;
        for (int w = 0; w < WAYS; w++) r[w] = MAX_WAY_BITS'(a[w]);
        return r;
    endfunction

    function automatic ages_t trim_ages(input age_vec_t a);
        ages_t r;
        r = '0;
        for (int w = 0; w < WAYS; w++) r[w] = WAY_BITS'(a[w]);
        return r;
    endfunction

    function automatic valid_vec_t pad_valid(input logic [WAYS-1:0] v);
        valid_vec_t r;
        r            = '0;
        r[WAYS-1:0]  = v;
        return r;
    endfunction

    assign accept = (state == ST_IDLE);

    // Descending scan so the lowest matching way is the one that sticks.
    always_comb begin
        lk_hit  = 1'b0;
        lk_way  = '0;
        inv_hit = 1'b0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_mem[lookup_set][w] && tag_mem[lookup_set][w] == lookup_tag) begin
                lk_hit = 1'b1;
                lk_way = WAY_BITS'(w);
            end
            if (valid_mem[inv_set][w] && tag_mem[inv_set][w] == inv_tag) begin
                inv_hit = 1'b1;
                inv_way = WAY_BITS'(w);
            end
        end
    end

    always_comb begin
        init_ages = '0;
        for (int w = 0; w < WAYS; w++) init_ages[w] = WAY_BITS'(w);
    end

    assign lk_victim = WAY_BITS'(victim_select(pad_valid(valid_mem[lookup_set]),
                                               pad_ages(age_mem[lookup_set]), WAYS));
    assign fl_victim = WAY_BITS'(victim_select(pad_valid(valid_mem[fill_set]),
                                               pad_ages(age_mem[fill_set]), WAYS));

    // Within one set only the highest-priority writer acts: fill, then invalidate, then hit LRU.
    assign fill_do = accept && fill_en;
    assign inv_do  = accept && inv_en && inv_hit && !(fill_do && inv_set == fill_set);
    assign lru_do  = accept && lookup_en && lk_hit
                     && !(fill_do && lookup_set == fill_set)
                     && !(inv_do && inv_set == lookup_set);

    assign upd_in_ages = fill_do ? age_mem[fill_set] : age_mem[lookup_set];
    assign upd_way     = fill_do ? fl_victim : lk_way;

    tag_lru_update #(
        .WAYS     (WAYS),
        .WAY_BITS (WAY_BITS)
    ) u_lru (
        .ages      (upd_in_ages),
        .way       (upd_way),
        .next_ages (upd_ages)
    );

    // A hit in a different set than a concurrent fill still needs its own age update.
    assign lk_next_ages = trim_ages(age_update(pad_ages(age_mem[lookup_set]),
                                               MAX_WAY_BITS'(lk_way), WAYS));

    // NOTE: the storage arrays are deliberately not reset; the INIT sweep clears valid/age and tags are don't-care until filled.
    always_ff @(posedge clk) begin
        if (state != ST_IDLE) begin
            valid_mem[sweep_cnt] <= '0;
            age_mem[sweep_cnt]   <= init_ages;
        end else begin
            if (fill_do) begin
                tag_mem[fill_set][fl_victim]   <= fill_tag;
                valid_mem[fill_set][fl_victim] <= 1'b1;
                age_mem[fill_set]              <= upd_ages;
            end
            if (inv_do) begin
                valid_mem[inv_set][inv_way] <= 1'b0;
            end
            if (lru_do) begin
                age_mem[lookup_set] <= fill_do ? lk_next_ages : upd_ages;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge gen_reset) begin
        if (!gen_reset) begin
            state      <= ST_INIT;
            sweep_cnt  <= '0;
            ready      <= 1'b0;
            hit_valid  <= 1'b0;
            hit        <= 1'b0;
            hit_way    <= '0;
            victim_way <= '0;
            fill_way   <= '0;
        end else begin
            unique case (state)
                ST_INIT, ST_FLUSH: begin
                    hit_valid <= 1'b0;
                    sweep_cnt <= sweep_cnt + SET_BITS'(1);
                    if (&sweep_cnt) begin
                        state <= ST_IDLE;
                        ready <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    hit_valid <= lookup_en;
                    if (lookup_en) begin
                        hit        <= lk_hit;
                        hit_way    <= lk_way;
                        victim_way <= lk_victim;
                    end
                    if (fill_en) begin
                        fill_way <= fl_victim;
                    end
                    if (flush_req) begin
                        state     <= ST_FLUSH;
                        ready     <= 1'b0;
                        sweep_cnt <= '0;
                    end
                end
                default: begin
                    state     <= ST_INIT;
                    ready     <= 1'b0;
                    sweep_cnt <= '0;
                    hit_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tag_array_assoc.sv
// Bench for tag_array_assoc: recency-timestamp cache model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_tag_array_assoc;

    localparam int SET_BITS = 2;
    localparam int TAG_W    = 8;
    localparam int WAYS     = 4;
    localparam int WAY_BITS = 2;
    localparam int SETS     = 1 << SET_BITS;

    logic                clk = 1'b0;
    logic                gen_reset;
    logic                ready;
    logic                flush_req;
    logic                lookup_en;
    logic [SET_BITS-1:0] lookup_set;
    logic [TAG_W-1:0]    lookup_tag;
    logic                hit_valid;
    logic                hit;
    logic [WAY_BITS-1:0] hit_way;
    logic [WAY_BITS-1:0] victim_way;
    logic                fill_en;
    logic [SET_BITS-1:0] fill_set;
    logic [TAG_W-1:0]    fill_tag;
    logic [WAY_BITS-1:0] fill_way;
    logic                inv_en;
    logic [SET_BITS-1:0] inv_set;
    logic [TAG_W-1:0]    inv_tag;

    tag_array_assoc #(
        .SET_BITS (SET_BITS),
        .TAG_W    (TAG_W),
        .WAYS     (WAYS)
    ) dut (
        .clk        (clk),
        .gen_reset  (gen_reset),
        .ready      (ready),
        .flush_req  (flush_req),
        .lookup_en  (lookup_en),
        .lookup_set (lookup_set),
        .lookup_tag (lookup_tag),
        .hit_valid  (hit_valid),
        .hit        (hit),
        .hit_way    (hit_way),
        .victim_way (victim_way),
        .fill_en    (fill_en),
        .fill_set   (fill_set),
        .fill_tag   (fill_tag),
        .fill_way   (fill_way),
        .inv_en     (inv_en),
        .inv_set    (inv_set),
        .inv_tag    (inv_tag)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: per line valid/tag and a last-use timestamp; LRU = oldest timestamp.
    bit m_valid [SETS][WAYS];
    int m_tag   [SETS][WAYS];
    int m_stamp [SETS][WAYS];
    int m_time;
    int sweep_left;

    bit chk_en = 1'b0;
    bit exp_ready, exp_hit_valid, exp_hit, exp_fill_chk;
    int exp_hit_way, exp_victim, exp_fill_way;

    function automatic void m_clear();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_stamp[s][w] = -w;
            end
        end
        m_time = 0;
    endfunction

    function automatic int m_match(input int s, input int t);
        for (int w = 0; w < WAYS; w++) begin
            if (m_valid[s][w] && m_tag[s][w] == t) return w;
        end
        return -1;
    endfunction

    function automatic int m_victim(input int s);
        int best;
        for (int w = 0; w < WAYS; w++) begin
            if (!m_valid[s][w]) return w;
        end
        best = 0;
        for (int w = 1; w < WAYS; w++) begin
            if (m_stamp[s][w] < m_stamp[s][best]) best = w;
        end
        return best;
    endfunction

    // Apply one clock of the currently driven requests to the model and the DUT.
    task automatic step();
        int lm = -1;
        int fv = -1;
        int im = -1;
        bit inv_eff = 1'b0;
        bit do_flush = 1'b0;
        bit n_hv = 1'b0;
        bit n_hit = 1'b0;
        bit n_fc = 1'b0;
        int n_hw = 0;
        int n_vw = 0;
        int n_fw = 0;
        int ls = int'(lookup_set);
        int fs = int'(fill_set);
        int is = int'(inv_set);
        if (sweep_left == 0) begin
            if (lookup_en) begin
                lm    = m_match(ls, int'(lookup_tag));
                n_hv  = 1'b1;
                n_hit = (lm >= 0);
                n_hw  = (lm >= 0) ? lm : 0;
                n_vw  = m_victim(ls);
            end
            if (fill_en) begin
                fv   = m_victim(fs);
                n_fc = 1'b1;
                n_fw = fv;
            end
            if (inv_en) im = m_match(is, int'(inv_tag));
            if (fill_en) begin
                m_valid[fs][fv] = 1'b1;
                m_tag[fs][fv]   = int'(fill_tag);
                m_time++;
                m_stamp[fs][fv] = m_time;
            end
            if (im >= 0 && !(fill_en && is == fs)) begin
                m_valid[is][im] = 1'b0;
                inv_eff = 1'b1;
            end
            if (lm >= 0 && !(fill_en && ls == fs) && !(inv_eff && is == ls)) begin
                m_time++;
                m_stamp[ls][lm] = m_time;
            end
            do_flush = flush_req;
        end
        @(posedge clk);
        if (sweep_left > 0) sweep_left--;
        if (do_flush) begin
            m_clear();
            sweep_left = SETS;
        end
        exp_ready     = (sweep_left == 0);
        exp_hit_valid = n_hv;
        exp_hit       = n_hit;
        exp_hit_way   = n_hw;
        exp_victim    = n_vw;
        exp_fill_chk  = n_fc;
        exp_fill_way  = n_fw;
        #1;
        lookup_en = 1'b0;
        fill_en   = 1'b0;
        inv_en    = 1'b0;
        flush_req = 1'b0;
    endtask

    task automatic do_lookup(input int s, input int t);
        lookup_en  = 1'b1;
        lookup_set = SET_BITS'(s);
        lookup_tag = TAG_W'(t);
        step();
    endtask

    task automatic do_fill(input int s, input int t);
        fill_en  = 1'b1;
        fill_set = SET_BITS'(s);
        fill_tag = TAG_W'(t);
        step();
    endtask

    task automatic do_inv(input int s, input int t);
        inv_en  = 1'b1;
        inv_set = SET_BITS'(s);
        inv_tag = TAG_W'(t);
        step();
    endtask

    task automatic apply_reset(input int cycles);
        gen_reset = 1'b0;
        m_clear();
        sweep_left    = SETS;
        exp_ready     = 1'b0;
        exp_hit_valid = 1'b0;
        exp_fill_chk  = 1'b0;
        #1;
        check("rst_ready", ready, 0);
        check("rst_hit_valid", hit_valid, 0);
        check("rst_hit", hit, 0);
        check("rst_hit_way", hit_way, 0);
        check("rst_victim_way", victim_way, 0);
        check("rst_fill_way", fill_way, 0);
        repeat (cycles) @(posedge clk);
        #1;
        gen_reset = 1'b1;
    endtask

    task automatic expect_sweep();
        for (int i = 0; i < SETS; i++) begin
            check("ready_low", ready, 0);
            step();
        end
        check("ready_high", ready, 1);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", ready, exp_ready);
            check("hit_valid", hit_valid, exp_hit_valid);
            if (exp_hit_valid) begin
                check("hit", hit, exp_hit);
                check("hit_way", hit_way, exp_hit_way);
                check("victim_way", victim_way, exp_victim);
            end
            if (exp_fill_chk) check("fill_way", fill_way, exp_fill_way);
        end
    end

    initial begin
        gen_reset  = 1'b1;
        flush_req  = 1'b0;
        lookup_en  = 1'b0;
        lookup_set = '0;
        lookup_tag = '0;
        fill_en    = 1'b0;
        fill_set   = '0;
        fill_tag   = '0;
        inv_en     = 1'b0;
        inv_set    = '0;
        inv_tag    = '0;
        m_clear();
        sweep_left = SETS;
        @(posedge clk);
        #1;
        apply_reset(2);
        chk_en = 1'b1;
        expect_sweep();

        for (int s = 0; s < SETS; s++) begin
            do_lookup(s, 5);
            check("init_miss", hit, 0);
            check("init_victim", victim_way, 0);
        end

        for (int i = 0; i < WAYS; i++) begin
            do_fill(1, 15 + i);
            check("fill_seq_way", fill_way, i);
        end
        do_lookup(1, 17);
        check("hit17", hit, 1);
        check("hit17_way", hit_way, 2);

        do_lookup(1, 15);
        check("hit15_way", hit_way, 0);
        do_fill(1, 31);
        check("fill31_lru_way", fill_way, 1);
        do_lookup(1, 16);
        check("evicted16_miss", hit, 0);
        do_lookup(1, 31);
        check("hit31", hit, 1);
        check("hit31_way", hit_way, 1);

        do_inv(1, 17);
        do_fill(1, 40);
        check("fill40_invalid_way", fill_way, 2);

        lookup_en  = 1'b1;
        lookup_set = 2'd1;
        lookup_tag = 8'd18;
        fill_en    = 1'b1;
        fill_set   = 2'd1;
        fill_tag   = 8'd50;
        step();
        check("same_set_hit", hit, 1);
        check("same_set_hit_way", hit_way, 3);
        check("same_set_fill_way", fill_way, 3);
        do_lookup(1, 50);
        check("hit50_way", hit_way, 3);
        do_lookup(1, 18);
        check("replaced18_miss", hit, 0);

        // Concurrent requests to distinct sets all take effect.
        lookup_en  = 1'b1;
        lookup_set = 2'd1;
        lookup_tag = 8'd40;
        fill_en    = 1'b1;
        fill_set   = 2'd2;
        fill_tag   = 8'd7;
        inv_en     = 1'b1;
        inv_set    = 2'd3;
        inv_tag    = 8'd9;
        step();
        check("multi_hit_way", hit_way, 2);
        check("multi_fill_way", fill_way, 0);

        // Invalidate and lookup-hit on the same set in one cycle.
        lookup_en  = 1'b1;
        lookup_set = 2'd1;
        lookup_tag = 8'd40;
        inv_en     = 1'b1;
        inv_set    = 2'd1;
        inv_tag    = 8'd31;
        step();
        do_fill(1, 60);
        check("fill60_way", fill_way, 1);

        for (int i = 0; i < 6; i++) do_fill(0, 100 + i);
        check("wrap_fill_way", fill_way, 1);
        do_lookup(0, 100);
        check("evicted100_miss", hit, 0);

        lookup_en  = 1'b1;
        lookup_set = 2'd1;
        lookup_tag = 8'd50;
        flush_req  = 1'b1;
        step();
        check("flush_cycle_hit", hit, 1);
        step();
        step();
        apply_reset(1);
        expect_sweep();

        for (int i = 0; i < 5; i++) begin
            int tags [5] = '{15, 31, 40, 50, 60};
            do_lookup(1, tags[i]);
            check("post_flush_miss", hit, 0);
        end
        do_lookup(2, 7);
        check("post_flush_miss2", hit, 0);
        do_lookup(0, 105);
        check("post_flush_miss0", hit, 0);
        check("post_flush_victim", victim_way, 0);

        @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
